// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_pipe_reg
//  Purpose  : IF/ID pipeline register for the RV32I 5-stage core. It also
//             owns front-end stall/flush control: PC write enable and the
//             ID/EX bubble request.
//  Options  : HAZARD_STATS_EN adds saturating stall/flush event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_pipe_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr_IF,
    input  logic [XLEN-1:0] pc_IF,
    input  logic [XLEN-1:0] pc_plus4_IF,
    input  logic            load_use_hazard_in,
    input  logic            branch_taken_in,
    output logic [31:0]     instr_IF_ID,
    output logic [XLEN-1:0] pc_IF_ID,
    output logic [XLEN-1:0] pc_plus4_IF_ID,
    output logic            valid_IF_ID,
    output logic [4:0]      rs1_IF_ID,
    output logic [4:0]      rs2_IF_ID,
    output logic            pc_write_en_out,
    output logic            id_ex_bubble_out
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic [CNT_W-1:0] flush_cnt_out
`endif
);

    localparam logic [1:0] c_ST_FILL = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    logic [1:0]      r_state;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    logic            w_in_fill;
    logic            w_stall;
    logic            w_flush;

    // EX holds only a bubble during FILL, so neither hazard can act then.
    assign w_in_fill = (r_state == c_ST_FILL);
    assign w_stall   = load_use_hazard_in & r_valid & ~w_in_fill;
    assign w_flush   = branch_taken_in & ~w_in_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_FILL;
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_FILL: begin
                    r_instr    <= instr_IF;
                    r_pc       <= pc_IF;
                    r_pc_plus4 <= pc_plus4_IF;
                    r_valid    <= 1'b1;
                    r_state    <= c_ST_RUN;
                end
                c_ST_RUN, c_ST_HOLD: begin
                    if (w_flush) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                        r_state <= c_ST_RUN;
                    end else if (w_stall) begin
                        r_state <= c_ST_HOLD;
                    end else begin
                        r_instr    <= instr_IF;
                        r_pc       <= pc_IF;
                        r_pc_plus4 <= pc_plus4_IF;
                        r_valid    <= 1'b1;
                        r_state    <= c_ST_RUN;
                    end
                end
                default: begin
                    r_instr <= NOP_INSTR;
                    r_valid <= 1'b0;
                    r_state <= c_ST_FILL;
                end
            endcase
        end
    end

    assign instr_IF_ID      = r_instr;
    assign pc_IF_ID         = r_pc;
    assign pc_plus4_IF_ID   = r_pc_plus4;
    assign valid_IF_ID      = r_valid;
    assign rs1_IF_ID        = r_valid ? r_instr[19:15] : 5'd0;
    assign rs2_IF_ID        = r_valid ? r_instr[24:20] : 5'd0;
    assign pc_write_en_out  = ~w_stall | branch_taken_in;
    assign id_ex_bubble_out = w_stall | branch_taken_in;

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_taken;

    // A flush pre-empts a concurrent stall, so only one event is counted.
    assign w_stall_taken = w_stall & ~w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_taken && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign stall_cnt_out = r_stall_cnt;
    assign flush_cnt_out = r_flush_cnt;
`else
    // Keeps CNT_W referenced when the counters are compiled out.
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule
`default_nettype wire
